// File: rtl/sram_param_bypass_clr.sv
// ---------------------------------------------------------------------------
// sram_param_bypass_clr
//
// Parametrised SRAM model for LSTM weight and state storage. One write port,
// one read port.
//   - Write path: request captured on one edge, committed to the array on the
//     next edge, with per-byte write enables.
//   - Read path: address registered on EN_M, DOUT is a combinational read of
//     the registered address.
//   - Optional bypass forwards the pending (captured, not yet committed) write
//     onto DOUT so a write is visible one cycle after WE.
//   - Clear engine zeroes every row, one row per cycle, after reset release
//     (CLEAR_ON_RESET=1) or on a CLR pulse while idle.
//
// Ports
//   CLK         in   1        clock, rising edge
//   RSTn        in   1        synchronous active-low reset
//   EN_M        in   1        read enable; captures ADDR
//   ADDR        in   ADDR_W   read address
//   WE          in   1        write request
//   ADDR_WRITE  in   ADDR_W   write address
//   DIN         in   DATA_W   write data
//   BE          in   BE_W     byte enables; bit i covers DIN[8i+7:8i]
//   CLR         in   1        clear request, honoured only while idle
//   DOUT        out  DATA_W   read data (zero while clearing or out of range)
//   READY       out  1        1 = idle, writes accepted
//   WR_DROP     out  1        one-cycle pulse: a write was discarded
// ---------------------------------------------------------------------------
module sram_param_bypass_clr #(
    parameter int DATA_W         = 128,
    parameter int DEPTH          = 2048,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int BE_W           = DATA_W / 8,
    parameter int CLEAR_ON_RESET = 1,
    parameter int BYPASS         = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN_M,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR_WRITE,
    input  logic [DATA_W-1:0] DIN,
    input  logic [BE_W-1:0]   BE,
    input  logic              CLR,
    output logic [DATA_W-1:0] DOUT,
    output logic              READY,
    output logic              WR_DROP
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    // DEPTH need not be a power of two, so the range check is done at 32 bits.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_write_q, addr_write_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Single array write port shared by the clear engine and the commit stage.
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BE_W-1:0]     mem_be;

    logic [DATA_W-1:0]   rd_row;

    // ------------------------------------------------------------------
    // Next-state, write capture/commit and clear sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = 1'b0;
        addr_write_d = addr_write_q;
        din_d        = din_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wr_drop_d    = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = cnt_q;
        mem_wdata    = '0;
        mem_be       = '0;

        if (EN_M) begin
            addr_d = ADDR;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (CLR) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    // The pending write would land mid-clear; drop it instead.
                    if (we_q) begin
                        wr_drop_d = 1'b1;
                    end
                end else if (we_q) begin
                    mem_we    = 1'b1;
                    mem_addr  = addr_write_q;
                    mem_wdata = din_q;
                    mem_be    = be_q;
                end

                // A new write is only accepted when the block stays idle and
                // the row exists; everything else is reported as a drop.
                if (WE) begin
                    if (!CLR && in_range(ADDR_WRITE)) begin
                        we_d         = 1'b1;
                        addr_write_d = ADDR_WRITE;
                        din_d        = DIN;
                        be_d         = BE;
                    end else begin
                        wr_drop_d = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                mem_be    = '1;
                if (32'(cnt_q) == 32'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
                if (WE) begin
                    wr_drop_d = 1'b1;
                end
            end

            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Write payload is qualified by we_q, so it carries no reset.
    always_ff @(posedge CLK) begin
        addr_write_q <= addr_write_d;
        din_q        <= din_d;
        be_q         <= be_d;
    end

    // ------------------------------------------------------------------
    // Array; contents are not touched by reset, but no write happens on a
    // reset edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RSTn && mem_we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path with optional forwarding of the pending write
    // ------------------------------------------------------------------
    always_comb begin
        rd_row = mem[addr_q];
        if (BYPASS != 0) begin
            if (we_q && (addr_write_q == addr_q)) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (be_q[b]) begin
                        rd_row[8*b +: 8] = din_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        DOUT = '0;
        if ((state_q == ST_IDLE) && in_range(addr_q)) begin
            DOUT = rd_row;
        end
    end

    assign READY   = (state_q == ST_IDLE);
    assign WR_DROP = wr_drop_q;

endmodule

// File: tb/tb_sram_param_bypass_clr.sv
// ---------------------------------------------------------------------------
// tb_sram_param_bypass_clr
//
// Directed bench for sram_param_bypass_clr. Three instances:
//   u_byp   : 128x2048, bypass on,  clear on reset
//   u_nobyp : 128x2048, bypass off, clear on reset (shares u_byp inputs)
//   u_small : 16x100,   bypass on,  no clear on reset (own inputs)
// ---------------------------------------------------------------------------
module tb_sram_param_bypass_clr;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         en_m;
    logic [10:0]  addr;
    logic         we;
    logic [10:0]  addr_write;
    logic [127:0] din;
    logic [15:0]  be;
    logic         clr;

    logic [127:0] dout_a, dout_b;
    logic         ready_a, ready_b, wr_drop_a, wr_drop_b;

    logic         s_en_m;
    logic [6:0]   s_addr;
    logic         s_we;
    logic [6:0]   s_addr_write;
    logic [15:0]  s_din;
    logic [1:0]   s_be;
    logic         s_clr;
    logic [15:0]  s_dout;
    logic         s_ready, s_wr_drop;

    int total = 0;
    int bad   = 0;
    int n;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_FF = {16{8'hFF}};
    localparam logic [127:0] PAT_33 = {16{8'h33}};
    localparam logic [127:0] X1     = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] X2     = 128'hdeadbeef00c0ffee_5a5a5a5a12345678;

    always #5 clk = ~clk;

    sram_param_bypass_clr #(
        .DATA_W(128), .DEPTH(2048), .CLEAR_ON_RESET(1), .BYPASS(1)
    ) u_byp (
        .CLK(clk), .RSTn(rst_n), .EN_M(en_m), .ADDR(addr), .WE(we),
        .ADDR_WRITE(addr_write), .DIN(din), .BE(be), .CLR(clr),
        .DOUT(dout_a), .READY(ready_a), .WR_DROP(wr_drop_a)
    );

    sram_param_bypass_clr #(
        .DATA_W(128), .DEPTH(2048), .CLEAR_ON_RESET(1), .BYPASS(0)
    ) u_nobyp (
        .CLK(clk), .RSTn(rst_n), .EN_M(en_m), .ADDR(addr), .WE(we),
        .ADDR_WRITE(addr_write), .DIN(din), .BE(be), .CLR(clr),
        .DOUT(dout_b), .READY(ready_b), .WR_DROP(wr_drop_b)
    );

    sram_param_bypass_clr #(
        .DATA_W(16), .DEPTH(100), .CLEAR_ON_RESET(0), .BYPASS(1)
    ) u_small (
        .CLK(clk), .RSTn(rst_n), .EN_M(s_en_m), .ADDR(s_addr), .WE(s_we),
        .ADDR_WRITE(s_addr_write), .DIN(s_din), .BE(s_be), .CLR(s_clr),
        .DOUT(s_dout), .READY(s_ready), .WR_DROP(s_wr_drop)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until u_byp reports READY; returns the tick count, -1 on timeout.
    task automatic wait_ready_a(input int start, output int cnt);
        cnt = start;
        while (!ready_a) begin
            tick();
            cnt++;
            if (cnt > 5000) begin
                cnt = -1;
                break;
            end
        end
    endtask

    task automatic read_a(input logic [10:0] a);
        en_m = 1'b1;
        addr = a;
        tick();
        en_m = 1'b0;
    endtask

    task automatic read_s(input logic [6:0] a);
        s_en_m = 1'b1;
        s_addr = a;
        tick();
        s_en_m = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en_m = 1'b0; addr = '0; we = 1'b0; addr_write = '0; din = '0; be = '0; clr = 1'b0;
        s_en_m = 1'b0; s_addr = '0; s_we = 1'b0; s_addr_write = '0; s_din = '0; s_be = '0;
        s_clr = 1'b0;

        // Reset state
        tick();
        check("rst_ready_a", 128'(ready_a), 128'(1'b0));
        check("rst_ready_b", 128'(ready_b), 128'(1'b0));
        check("rst_drop_a", 128'(wr_drop_a), 128'(1'b0));
        check("rst_dout_a", dout_a, '0);
        check("rst_ready_s", 128'(s_ready), 128'(1'b1));
        check("rst_drop_s", 128'(s_wr_drop), 128'(1'b0));

        // Clear after reset release lasts exactly DEPTH cycles
        rst_n = 1'b1;
        wait_ready_a(0, n);
        check("rstclr_len", 128'(n), 128'(2048));
        check("rstclr_ready_b", 128'(ready_b), 128'(1'b1));

        read_a(11'd0);    check("clr_row0", dout_a, '0);
        read_a(11'd1234); check("clr_row1234", dout_a, '0);
        read_a(11'd2047); check("clr_row2047", dout_a, '0);

        // Write to row 5 with read of row 5 in the same cycle
        we = 1'b1; addr_write = 11'd5; din = PAT_A5; be = '1;
        en_m = 1'b1; addr = 11'd5;
        tick();
        we = 1'b0; en_m = 1'b0;
        check("byp_early", dout_a, PAT_A5);
        check("nobyp_early", dout_b, '0);
        tick();
        check("byp_late", dout_a, PAT_A5);
        check("nobyp_late", dout_b, PAT_A5);
        check("wr5_nodrop", 128'(wr_drop_a), 128'(1'b0));

        // Single-byte write over an all-0xFF row
        en_m = 1'b1; addr = 11'd7;
        we = 1'b1; addr_write = 11'd7; din = PAT_FF; be = '1;
        tick();
        we = 1'b0;
        tick();
        we = 1'b1; din = '0; be = 16'h0001;
        tick();
        we = 1'b0;
        check("be_byp", dout_a, {PAT_FF[127:8], 8'h00});
        check("be_nobyp_pending", dout_b, PAT_FF);
        tick();
        en_m = 1'b0;
        check("be_commit_a", dout_a, {PAT_FF[127:8], 8'h00});
        check("be_commit_b", dout_b, {PAT_FF[127:8], 8'h00});

        // Back-to-back writes to adjacent rows, then a BE=0 write
        we = 1'b1; addr_write = 11'd10; din = X1; be = '1;
        tick();
        addr_write = 11'd11; din = X2;
        tick();
        addr_write = 11'd10; din = '1; be = '0;
        tick();
        we = 1'b0;
        check("be0_nodrop", 128'(wr_drop_a), 128'(1'b0));
        tick();
        read_a(11'd10); check("b2b_row10", dout_a, X1);
        check("b2b_row10_b", dout_b, X1);
        read_a(11'd11); check("b2b_row11", dout_a, X2);

        // CLR with a pending write, writes during clear, CLR ignored mid-clear
        we = 1'b1; addr_write = 11'd3; din = PAT_33; be = '1;
        tick();
        we = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_pending_drop", 128'(wr_drop_a), 128'(1'b1));
        check("clr_ready_low", 128'(ready_a), 128'(1'b0));
        we = 1'b1; addr_write = 11'd20; din = X1;
        tick();
        we = 1'b0;
        check("clr_we_drop", 128'(wr_drop_a), 128'(1'b1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_drop_end", 128'(wr_drop_a), 128'(1'b0));
        wait_ready_a(2, n);
        check("clr_len", 128'(n), 128'(2048));
        read_a(11'd3);  check("clr_row3", dout_a, '0);
        read_a(11'd7);  check("clr_row7", dout_a, '0);
        read_a(11'd10); check("clr_row10", dout_a, '0);

        // Reset while the clear engine is at row 500
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (500) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_ready", 128'(ready_a), 128'(1'b0));
        check("midrst_ready_s", 128'(s_ready), 128'(1'b1));
        wait_ready_a(0, n);
        check("midrst_len", 128'(n), 128'(2048));

        // Small instance: CLR-driven clear, then out-of-range write
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        check("s_clr_ready_low", 128'(s_ready), 128'(1'b0));
        n = 0;
        while (!s_ready && n <= 1000) begin
            tick();
            n++;
        end
        check("s_clr_len", 128'(n), 128'(100));
        s_we = 1'b1; s_addr_write = 7'd99; s_din = 16'hBEEF; s_be = 2'b11;
        tick();
        s_we = 1'b0;
        check("s_wr99_nodrop", 128'(s_wr_drop), 128'(1'b0));
        tick();
        s_we = 1'b1; s_addr_write = 7'd120; s_din = 16'h1234;
        s_en_m = 1'b1; s_addr = 7'd120;
        tick();
        s_we = 1'b0; s_en_m = 1'b0;
        check("s_oor_drop", 128'(s_wr_drop), 128'(1'b1));
        check("s_oor_dout_byp", 128'(s_dout), 128'(16'h0000));
        tick();
        check("s_oor_drop_end", 128'(s_wr_drop), 128'(1'b0));
        read_s(7'd120); check("s_oor_read", 128'(s_dout), 128'(16'h0000));
        read_s(7'd99);  check("s_row99", 128'(s_dout), 128'(16'hBEEF));
        read_s(7'd20);  check("s_row20", 128'(s_dout), 128'(16'h0000));
        read_s(7'd0);   check("s_row0", 128'(s_dout), 128'(16'h0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
